// File: rtl/chess_timer_pkg.sv
// Shared encodings for the chess timer: FSM states and player indices.
package chess_timer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P1_RUN = 3'd1,
    P2_RUN = 3'd2,
    PAUSED = 3'd3,
    FLAG   = 3'd4
  } state_t;

  localparam int unsigned P1 = 0;
  localparam int unsigned P2 = 1;

  // Bit positions inside the edge-detector vector {start, pause, btn[1:0]}
  localparam int unsigned EV_BTN1  = 1;
  localparam int unsigned EV_PAUSE = 2;
  localparam int unsigned EV_START = 3;
  localparam int unsigned EV_W     = 4;

endpackage

// File: rtl/rise_detect.sv
// N-bit rising-edge detector: one-cycle pulse when a level input first samples high.
module rise_detect #(
  parameter int unsigned N = 1
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [N-1:0] i_level,
  output logic [N-1:0] o_rise
);

  logic [N-1:0] level_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) level_q <= '0;
    else            level_q <= i_level;
  end

  assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/chess_turn_scheduler.sv
// Two-player countdown sequencer: run/handoff/pause/flag-fall over both time registers.
// Optional Fischer increment on handoff is enabled by defining FISCHER_INC_EN.
module chess_turn_scheduler
  import chess_timer_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned INIT_TIME = 10,
  parameter int unsigned INC_TIME  = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic [1:0]       i_btn,
  output logic [WIDTH-1:0] o_time1,
  output logic [WIDTH-1:0] o_time2,
  output logic [2:0]       o_state,
  output logic [1:0]       o_flag,
  output logic [7:0]       o_moves
);

`ifdef FISCHER_INC_EN
  localparam logic INC_ON = 1'b1;
`else
  localparam logic INC_ON = 1'b0;
`endif
  localparam logic [WIDTH:0]   INC_ADD = INC_ON ? (WIDTH+1)'(INC_TIME) : '0;
  localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT_TIME);

  state_t state;
  logic   paused_runner;

  logic [EV_W-1:0] rise;
  logic            start_rise;
  logic            pause_rise;
  logic            runner;
  logic            runner_btn_rise;
  logic [WIDTH-1:0] run_time;
  logic [WIDTH-1:0] dec_time;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] mover_time;
  logic             flag_fall;

  rise_detect #(.N(EV_W)) u_rise (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_level   ({i_start, i_pause, i_btn}),
    .o_rise    (rise)
  );

  assign start_rise = rise[EV_START];
  assign pause_rise = rise[EV_PAUSE];

  // Runner-relative view so P1_RUN and P2_RUN share one datapath
  always_comb begin
    runner          = (state == P2_RUN);
    run_time        = runner ? o_time2 : o_time1;
    runner_btn_rise = runner ? rise[EV_BTN1] : rise[P1];
    dec_time        = i_tick ? (run_time - WIDTH'(1)) : run_time;
    flag_fall       = i_tick && (run_time == WIDTH'(1));
    inc_sum         = {1'b0, dec_time} + INC_ADD;
    mover_time      = inc_sum[WIDTH] ? '1 : inc_sum[WIDTH-1:0];
  end

  assign o_state = state;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      paused_runner <= 1'b0;
      o_time1       <= INIT_V;
      o_time2       <= INIT_V;
      o_flag        <= '0;
      o_moves       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_rise) state <= P1_RUN;
        end
        P1_RUN, P2_RUN: begin
          // Priority: flag-fall, pause, handoff, plain decrement
          if (flag_fall) begin
            if (runner) o_time2 <= '0;
            else        o_time1 <= '0;
            o_flag[runner] <= 1'b1;
            state          <= FLAG;
          end else if (pause_rise) begin
            paused_runner <= runner;
            state         <= PAUSED;
          end else if (runner_btn_rise) begin
            if (runner) o_time2 <= mover_time;
            else        o_time1 <= mover_time;
            o_moves <= o_moves + 8'd1;
            state   <= runner ? P1_RUN : P2_RUN;
          end else if (i_tick) begin
            if (runner) o_time2 <= dec_time;
            else        o_time1 <= dec_time;
          end
        end
        PAUSED: begin
          if (pause_rise) state <= paused_runner ? P2_RUN : P1_RUN;
        end
        FLAG: begin
          if (start_rise) begin
            o_time1 <= INIT_V;
            o_time2 <= INIT_V;
            o_flag  <= '0;
            o_moves <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chess_turn_scheduler.sv
// Scoreboard bench for chess_turn_scheduler: directed scenarios then randomized traffic.
module tb_chess_turn_scheduler;

  localparam int W    = 10;
  localparam int INIT = 10;
  localparam int INC  = 2;
`ifdef FISCHER_INC_EN
  localparam bit FISCHER = 1'b1;
`else
  localparam bit FISCHER = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic [1:0]   btn = 2'b00;
  logic [W-1:0] time1, time2;
  logic [2:0]   state;
  logic [1:0]   flag;
  logic [7:0]   moves;

  chess_turn_scheduler #(.WIDTH(W), .INIT_TIME(INIT), .INC_TIME(INC)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_tick    (tick),
    .i_start   (start),
    .i_pause   (pause),
    .i_btn     (btn),
    .o_time1   (time1),
    .o_time2   (time2),
    .o_state   (state),
    .o_flag    (flag),
    .o_moves   (moves)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t1;
    int t2;
    int st;
    int fl;
    int mv;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: game phase, who is on move, clocks, last seen input levels
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_FLAG = 3;
  int mode = M_IDLE;
  int runner = 0;
  int tm[2] = '{INIT, INIT};
  int mv = 0;
  int fl = 0;
  bit prev_s = 0, prev_p = 0;
  bit [1:0] prev_b = 2'b00;

  function automatic int state_code();
    case (mode)
      M_IDLE:   return 0;
      M_RUN:    return 1 + runner;
      M_PAUSED: return 3;
      default:  return 4;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit p, input bit [1:0] b,
                      input bit t, input bit glitch = 1'b0);
    bit sr, pr;
    bit [1:0] br;
    exp_t e;
    @(negedge clk);
    rst_n = r; start = s; pause = p; btn = b; tick = t;
    if (!r) begin
      mode = M_IDLE; runner = 0; tm[0] = INIT; tm[1] = INIT; mv = 0; fl = 0;
      prev_s = 0; prev_p = 0; prev_b = 2'b00;
    end else begin
      sr = s && !prev_s;
      pr = p && !prev_p;
      br = b & ~prev_b;
      prev_s = s; prev_p = p; prev_b = b;
      case (mode)
        M_IDLE: if (sr) begin mode = M_RUN; runner = 0; end
        M_RUN: begin
          if (t && tm[runner] == 1) begin
            tm[runner] = 0;
            fl |= (1 << runner);
            mode = M_FLAG;
          end else if (pr) begin
            mode = M_PAUSED;
          end else if (br[runner]) begin
            if (t) tm[runner] -= 1;
            if (FISCHER) begin
              tm[runner] += INC;
              if (tm[runner] > (1 << W) - 1) tm[runner] = (1 << W) - 1;
            end
            runner = 1 - runner;
            mv = (mv + 1) % 256;
          end else if (t) begin
            tm[runner] -= 1;
          end
        end
        M_PAUSED: if (pr) mode = M_RUN;
        default: if (sr) begin
          mode = M_IDLE; tm[0] = INIT; tm[1] = INIT; fl = 0; mv = 0;
        end
      endcase
    end
    e.t1 = tm[0]; e.t2 = tm[1]; e.st = state_code(); e.fl = fl; e.mv = mv;
    q.push_back(e);
    if (glitch) begin
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
    end
  endtask

  // Monitor: every clock edge the DUT presents a new state; compare against the queue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("time1", int'(time1), e.t1);
        check("time2", int'(time2), e.t2);
        check("state", int'(state), e.st);
        check("flag",  int'(flag),  e.fl);
        check("moves", int'(moves), e.mv);
      end
    end
  end

  initial begin
    int guard;
    bit s, p, t, r;
    bit [1:0] b;

    step(0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 2'b11, 1);
    // start then three ticks
    step(1, 1, 0, 2'b00, 0);
    repeat (3) step(1, 1, 0, 2'b00, 1);
    // handoff to P2, two ticks, then P2 button held for five cycles
    step(1, 0, 0, 2'b01, 0);
    repeat (2) step(1, 0, 0, 2'b01, 1);
    repeat (5) step(1, 0, 0, 2'b10, 0);
    step(1, 0, 0, 2'b00, 0);
    // pause freezes time and drops buttons; resume returns to P1
    guard = 0;
    while (tm[0] > 5 && guard < 50) begin step(1, 0, 0, 2'b00, 1); guard++; end
    step(1, 0, 1, 2'b00, 0);
    repeat (4) step(1, 0, 1, 2'b00, 1);
    step(1, 0, 1, 2'b01, 0);
    step(1, 0, 0, 2'b00, 0);
    step(1, 0, 1, 2'b00, 0);
    step(1, 0, 0, 2'b00, 1);
    // run P1 down to 1, then tick and handoff together
    guard = 0;
    while (tm[0] > 1 && guard < 50) begin step(1, 0, 0, 2'b00, 1); guard++; end
    step(1, 0, 0, 2'b01, 1);
    step(1, 0, 0, 2'b00, 1);
    step(1, 0, 0, 2'b10, 1);
    step(1, 0, 1, 2'b01, 1);
    step(1, 1, 0, 2'b00, 0);
    // restart, move to P2, reset mid-run, then a sub-cycle reset glitch
    step(1, 0, 0, 2'b00, 0);
    step(1, 1, 0, 2'b00, 0);
    step(1, 1, 0, 2'b01, 1);
    step(1, 1, 0, 2'b00, 1);
    step(0, 1, 0, 2'b00, 1);
    step(1, 0, 0, 2'b00, 0);
    step(1, 1, 0, 2'b00, 0);
    step(1, 1, 0, 2'b00, 1, 1'b1);
    step(1, 1, 0, 2'b01, 1, 1'b1);
    step(1, 1, 0, 2'b00, 1);

    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 399) != 0);
      s = ($urandom_range(0, 9) == 0) ? ~start : start;
      p = ($urandom_range(0, 11) == 0) ? ~pause : pause;
      b = btn;
      if ($urandom_range(0, 3) == 0) b[0] = ~b[0];
      if ($urandom_range(0, 3) == 0) b[1] = ~b[1];
      t = ($urandom_range(0, 2) == 0);
      step(r, s, p, b, t);
    end

    step(1, 0, 0, 2'b00, 0);
    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
